// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer: FSM states, index width, dwell width default.
package scan_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int IDX_W       = 3;
   localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/dwell_timer.sv
// Per-index hold counter: expire pulses combinationally once the count reaches limit (limit+1 cycles per index).
// Count is cleared on clr, while disabled and on expiry; no backpressure.
module dwell_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] cnt_q;

   assign expire = en && (cnt_q == limit);

   always_ff @(posedge clk) begin
      if (rst || clr || !en || expire) cnt_q <= '0;
      else                             cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/scan_sequencer.sv
// Index scanner driving 3-to-8 decoder selects; all outputs registered, one cycle after start/stop/expiry.
// No backpressure; SCAN_PINGPONG_EN adds the pingpong input for up/down continuous scans.
module scan_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               oneshot,
`ifdef SCAN_PINGPONG_EN
   input  logic               pingpong,
`endif
   input  logic [2:0]         last,
   input  logic [DWELL_W-1:0] dwell,
   output logic               s0,
   output logic               s1,
   output logic               s2,
   output logic               active,
   output logic               done,
   output logic               wrap
);

   state_t               state_q, state_nxt;
   logic [IDX_W-1:0]     idx_q, idx_nxt;
   logic [IDX_W-1:0]     last_q, last_nxt;
   logic [DWELL_W-1:0]   dwell_q, dwell_nxt;
   logic                 oneshot_q, oneshot_nxt;
   logic                 down_q, down_nxt;
   logic                 done_q, done_nxt;
   logic                 wrap_q, wrap_nxt;
   logic                 active_q;
   logic                 pp_mode;
   logic                 expire;

`ifdef SCAN_PINGPONG_EN
   logic pp_q;

   always_ff @(posedge clk) begin
      if (rst)                 pp_q <= 1'b0;
      else if (start && !stop) pp_q <= pingpong;
   end

   assign pp_mode = pp_q;
`else
   assign pp_mode = 1'b0;
`endif

   dwell_timer #(.W(DWELL_W)) u_dwell_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (start || stop),
      .en     (state_q == SCAN),
      .limit  (dwell_q),
      .expire (expire)
   );

   always_comb begin
      state_nxt   = state_q;
      idx_nxt     = idx_q;
      last_nxt    = last_q;
      dwell_nxt   = dwell_q;
      oneshot_nxt = oneshot_q;
      down_nxt    = down_q;
      done_nxt    = 1'b0;
      wrap_nxt    = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         down_nxt  = 1'b0;
      end else if (start) begin
         state_nxt   = SCAN;
         idx_nxt     = '0;
         down_nxt    = 1'b0;
         last_nxt    = last;
         dwell_nxt   = dwell;
         oneshot_nxt = oneshot;
      end else if (state_q == SCAN && expire) begin
         if (down_q) begin
            idx_nxt = idx_q - 1'b1;
            if (idx_q == 1) begin
               wrap_nxt = 1'b1;
               down_nxt = 1'b0;
            end
         end else if (idx_q != last_q) begin
            idx_nxt = idx_q + 1'b1;
         end else if (oneshot_q) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
         end else if (pp_mode && last_q != 0) begin
            // Turn at the top; a range of 0..1 lands straight back on 0
            idx_nxt = last_q - 1'b1;
            if (last_q == 1) wrap_nxt = 1'b1;
            else             down_nxt = 1'b1;
         end else begin
            idx_nxt  = '0;
            wrap_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         dwell_q   <= '0;
         oneshot_q <= 1'b0;
         down_q    <= 1'b0;
         done_q    <= 1'b0;
         wrap_q    <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         idx_q     <= idx_nxt;
         last_q    <= last_nxt;
         dwell_q   <= dwell_nxt;
         oneshot_q <= oneshot_nxt;
         down_q    <= down_nxt;
         done_q    <= done_nxt;
         wrap_q    <= wrap_nxt;
         active_q  <= (state_nxt == SCAN);
      end
   end

   assign s0     = idx_q[0];
   assign s1     = idx_q[1];
   assign s2     = idx_q[2];
   assign active = active_q;
   assign done   = done_q;
   assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; each check packs {s2,s1,s0,active,done,wrap}.
// Define SCAN_PINGPONG_EN to include the pingpong scenarios.
module tb_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, stop, oneshot;
   logic [2:0] last;
   logic [7:0] dwell;
   logic       s0, s1, s2, active, done, wrap;
`ifdef SCAN_PINGPONG_EN
   logic       pingpong;
`endif
   int         n_chk  = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   scan_sequencer #(.DWELL_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .oneshot (oneshot),
`ifdef SCAN_PINGPONG_EN
      .pingpong(pingpong),
`endif
      .last    (last),
      .dwell   (dwell),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .active  (active),
      .done    (done),
      .wrap    (wrap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %06b expected %06b", tag, obs[5:0], exp[5:0]);
   endtask

   function automatic logic [31:0] ex(input int idx, input bit act, input bit dn, input bit wr);
      logic [2:0] i3;
      i3 = idx[2:0];
      return {26'd0, i3, act, dn, wr};
   endfunction

   function automatic logic [31:0] obs_now();
      return {26'd0, s2, s1, s0, active, done, wrap};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_scan(input bit os, input int lst, input int dw);
      oneshot = os;
      last    = lst[2:0];
      dwell   = dw[7:0];
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   initial begin
      int os_seq[8];
      rst = 1'b1; start = 1'b1; stop = 1'b0; oneshot = 1'b0; last = 3'd0; dwell = 8'd0;
`ifdef SCAN_PINGPONG_EN
      pingpong = 1'b0;
`endif
      // reset dominates a held start
      step(); chk("rst_0", obs_now(), ex(0, 0, 0, 0));
      step(); chk("rst_1", obs_now(), ex(0, 0, 0, 0));
      rst = 1'b0; start = 1'b0;
      step(); chk("idle", obs_now(), ex(0, 0, 0, 0));

      // oneshot last=3 dwell=1; inputs scrambled after start must be ignored
      os_seq = '{0, 0, 1, 1, 2, 2, 3, 3};
      begin_scan(1, 3, 1);
      oneshot = 1'b0; last = 3'd7; dwell = 8'd5;
      chk("os_0", obs_now(), ex(os_seq[0], 1, 0, 0));
      for (int i = 1; i < 8; i++) begin
         step(); chk($sformatf("os_%0d", i), obs_now(), ex(os_seq[i], 1, 0, 0));
      end
      step(); chk("os_done", obs_now(), ex(0, 0, 1, 0));
      step(); chk("os_after", obs_now(), ex(0, 0, 0, 0));

      // continuous last=7 dwell=0, two full laps
      begin_scan(0, 7, 0);
      chk("cont_0", obs_now(), ex(0, 1, 0, 0));
      for (int i = 1; i <= 16; i++) begin
         step(); chk($sformatf("cont_%0d", i), obs_now(), ex(i % 8, 1, 0, (i % 8) == 0));
      end
      stop = 1'b1; step(); stop = 1'b0;
      chk("cont_stop", obs_now(), ex(0, 0, 0, 0));

      // stop at index 2 of last=5, then start+stop together from IDLE
      begin_scan(1, 5, 0);
      step(); step(); chk("stp_idx2", obs_now(), ex(2, 1, 0, 0));
      stop = 1'b1; step(); stop = 1'b0;
      chk("stp_idle", obs_now(), ex(0, 0, 0, 0));
      step(); chk("stp_nodone", obs_now(), ex(0, 0, 0, 0));
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      chk("ss_idle", obs_now(), ex(0, 0, 0, 0));
      step(); chk("ss_idle2", obs_now(), ex(0, 0, 0, 0));

      // restart at index 4 with last 6 -> 2
      begin_scan(0, 6, 0);
      for (int i = 1; i <= 4; i++) step();
      chk("rs_idx4", obs_now(), ex(4, 1, 0, 0));
      begin_scan(0, 2, 0);
      chk("rs_0", obs_now(), ex(0, 1, 0, 0));
      step(); chk("rs_1", obs_now(), ex(1, 1, 0, 0));
      step(); chk("rs_2", obs_now(), ex(2, 1, 0, 0));
      step(); chk("rs_wrap", obs_now(), ex(0, 1, 0, 1));
      step(); chk("rs_1b", obs_now(), ex(1, 1, 0, 0));

      // reset mid-scan at index=last: no wrap, back to IDLE
      begin_scan(0, 3, 0);
      step(); step(); step(); chk("mr_idx3", obs_now(), ex(3, 1, 0, 0));
      rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
      chk("mr_rst", obs_now(), ex(0, 0, 0, 0));
      step(); chk("mr_idle", obs_now(), ex(0, 0, 0, 0));

      // last=0 continuous dwell=2: wrap every third cycle, index stays 0
      begin_scan(0, 0, 2);
      chk("l0_0", obs_now(), ex(0, 1, 0, 0));
      for (int i = 1; i <= 6; i++) begin
         step(); chk($sformatf("l0_%0d", i), obs_now(), ex(0, 1, 0, (i % 3) == 0));
      end
      // last=0 oneshot dwell=0: done on the first expiry
      begin_scan(1, 0, 0);
      chk("l0os_0", obs_now(), ex(0, 1, 0, 0));
      step(); chk("l0os_done", obs_now(), ex(0, 0, 1, 0));
      step(); chk("l0os_idle", obs_now(), ex(0, 0, 0, 0));

`ifdef SCAN_PINGPONG_EN
      begin
         int pp_seq[9];
         pp_seq = '{0, 1, 2, 1, 0, 1, 2, 1, 0};
         pingpong = 1'b1;
         begin_scan(0, 2, 0);
         chk("pp_0", obs_now(), ex(0, 1, 0, 0));
         for (int i = 1; i < 9; i++) begin
            step(); chk($sformatf("pp_%0d", i), obs_now(), ex(pp_seq[i], 1, 0, (i % 4) == 0));
         end
         // oneshot ignores pingpong
         begin_scan(1, 2, 0);
         step(); step(); chk("ppos_2", obs_now(), ex(2, 1, 0, 0));
         step(); chk("ppos_done", obs_now(), ex(0, 0, 1, 0));
         pingpong = 1'b0;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the width of the dwell-count input.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, which begins a scan.
REQ-005 The block SHALL have port stop, input, 1, which aborts a scan.
REQ-006 The block SHALL have port oneshot, input, 1, selecting mode: 1 = single pass, 0 = continuous; sampled with start.
REQ-007 The block SHALL have port last, input, 3, giving the final index of the scan range 0..last; sampled with start.
REQ-008 The block SHALL have port dwell, input, DWELL_W, holding each index for dwell+1 cycles; sampled with start.
REQ-009 The block SHALL have ports s0, s1, s2, output, 1 each, carrying the registered index bits (s2 = MSB) that feed the 3-to-8 decoder select inputs.
REQ-010 The block SHALL have port active, output, 1, high while in SCAN.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse at the end of a oneshot pass.
REQ-012 The block SHALL have port wrap, output, 1, a one-cycle pulse when the index returns to 0 in continuous mode.

Function
REQ-013 The FSM SHALL have states IDLE and SCAN; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 SHALL latch last, dwell and oneshot, clear the dwell timer and set the index to 0, with SCAN/active=1 from the next cycle.
REQ-015 In SCAN, the index SHALL be held for exactly dwell+1 cycles; on dwell expiry it SHALL advance by 1 (dwell=0 gives an advance every cycle).
REQ-016 In continuous mode, on expiry at index=last, the index SHALL become 0 and wrap SHALL pulse in that same cycle.
REQ-017 In oneshot mode, on expiry at index=last, the FSM SHALL go to IDLE, the index SHALL go to 0, done SHALL pulse for one cycle and active SHALL drop.
REQ-018 With last=0, the index SHALL stay 0; wrap or done SHALL fire on every dwell expiry.
REQ-019 stop=1 in SCAN SHALL give IDLE next cycle with index=0, active=0 and no done or wrap pulse.
REQ-020 Simultaneous start and stop SHALL resolve in favour of stop.
REQ-021 start=1 in SCAN (without stop) SHALL restart the scan: re-latch the inputs, set index=0 and clear the timer.
REQ-022 Changes to last, dwell or oneshot during SCAN SHALL have no effect until the next start.
REQ-023 In IDLE, s2..s0 SHALL be held at 0.

Reset
REQ-024 rst=1 SHALL force IDLE, index 0 (s0=s1=s2=0), active=0, done=0, wrap=0, timer 0 and latched registers 0 on the next edge.
REQ-025 rst SHALL take priority over start and stop, and an assertion mid-scan SHALL abort without emitting done or wrap.

Configuration
REQ-026 Macro SCAN_PINGPONG_EN, when defined, SHALL add a 1-bit input pingpong, sampled with start.
REQ-027 When SCAN_PINGPONG_EN is defined and pingpong=1 in continuous mode, the sequence SHALL be 0,1..last,last-1..1,0,1..; wrap SHALL pulse on arrival at 0 while descending; each index, including the turn points, SHALL dwell once.
REQ-028 When SCAN_PINGPONG_EN is defined, oneshot SHALL ignore pingpong (up pass only).
REQ-029 When SCAN_PINGPONG_EN is undefined, the port and its logic SHALL be absent and the behaviour SHALL equal pingpong=0.

Structure
REQ-030 Package scan_seq_pkg SHALL hold the FSM state typedef (IDLE, SCAN), the index width constant 3 and the DWELL_W default.
REQ-031 Sub-module dwell_timer (load, count, expire pulse) SHALL implement the per-index hold; there SHALL be no other sub-modules.

Verification
REQ-032 Scenario: rst held 2 cycles with start=1 -> s2..s0=000, active=0, done=0, wrap=0 throughout.
REQ-033 Scenario: oneshot=1, last=3, dwell=1, start pulse -> indices 0,0,1,1,2,2,3,3, then done pulse one cycle, active=0, index 0.
REQ-034 Scenario: oneshot=0, last=7, dwell=0 -> 0..7,0..7 every cycle, wrap high exactly on cycles where index becomes 0 after 7.
REQ-035 Scenario: stop at index 2 (last=5) -> next cycle IDLE, index 0, no done; start and stop asserted together from IDLE -> stays IDLE.
REQ-036 Scenario: start re-asserted at index 4 with last changed 6->2 -> index 0 next cycle, new range 0..2.
REQ-037 Scenario: SCAN_PINGPONG_EN defined, pingpong=1, last=2, dwell=0 -> 0,1,2,1,0,1,2,1,0 with wrap on each return to 0.
